pulse_stretch: RTL and testbench

Tick-to-level generator: the inverse of the rising-edge detector. Each single-cycle `tick` input produces exactly one output pulse: `level` high for HIGH_CYCLES, then low for at least GAP_CYCLES. Ticks that arrive while a pulse or gap is in progress are queued, up to a bounded depth, and replayed, so a downstream edge detector recovers one tick per input tick. The block drives indicator, buzzer and turn-signal style outputs in the mobile datapath from controller-generated ticks.

---
 rtl/mobile_pkg.sv | 19 +
 rtl/sat_updown_cnt.sv | 41 ++++
 rtl/pulse_stretch.sv | 103 ++++++++++
 tb/tb_pulse_stretch.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mobile_pkg.sv
// Shared types and defaults for the mobile-datapath event blocks.
// Holds the pulse FSM state encoding and the default timing constants.
package mobile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int DEF_HIGH_CYCLES = 4;
    localparam int DEF_GAP_CYCLES  = 2;
    localparam int DEF_PEND_W      = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter for queued events: floors at zero, holds at all-ones,
// and flags a dropped increment with a one-cycle registered overflow pulse.
module sat_updown_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_overflow
);

    localparam logic [W-1:0] MAX_COUNT = '1;

    logic [W-1:0] r_count;
    logic         r_overflow;

    // Simultaneous inc and dec cancel, so a saturated counter never reports a drop then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            if (i_inc && !i_dec) begin
                if (r_count == MAX_COUNT) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end else if (i_dec && !i_inc && (r_count != '0)) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/pulse_stretch.sv
// Tick-to-level generator: each input tick yields one HIGH_CYCLES-wide pulse followed by
// at least GAP_CYCLES low; ticks arriving while busy are queued and replayed.
module pulse_stretch
    import mobile_pkg::*;
#(
    parameter int HIGH_CYCLES = DEF_HIGH_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int PEND_W      = DEF_PEND_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    output logic              level,
    output logic              busy,
    output logic [PEND_W-1:0] pend,
    output logic              overflow
);

    localparam int CNT_MAX = max_int(HIGH_CYCLES, GAP_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_level;
    logic               r_busy;
    logic               w_gap_end;
    logic               w_consume;
    logic               w_enqueue;
    logic [PEND_W-1:0]  w_pend;
    logic               w_overflow;

    // A tick on the last gap cycle with an empty queue launches the next pulse directly;
    // modelling it as enqueue+consume keeps the counter at zero.
    assign w_gap_end = (r_state == ST_GAP) && (r_cnt == '0);
    assign w_consume = w_gap_end && ((w_pend != '0) || tick);
    assign w_enqueue = tick && r_busy;

    sat_updown_cnt #(
        .W (PEND_W)
    ) u_pend_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_inc      (w_enqueue),
        .i_dec      (w_consume),
        .o_count    (w_pend),
        .o_overflow (w_overflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (tick) begin
                        r_state <= ST_HIGH;
                        r_cnt   <= HIGH_LOAD;
                        r_level <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state <= ST_GAP;
                        r_cnt   <= GAP_LOAD;
                        r_level <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_consume) begin
                        r_state <= ST_HIGH;
                        r_cnt   <= HIGH_LOAD;
                        r_level <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign level    = r_level;
    assign busy     = r_busy;
    assign pend     = w_pend;
    assign overflow = w_overflow;

endmodule

// File: tb/tb_pulse_stretch.sv
// Randomized bench for pulse_stretch: two instances (default timing and 1/1 timing) checked
// every cycle against a timestamp-based model of pulses and the pending-request count.
module tb_pulse_stretch;

    localparam int H_A = 4, G_A = 2, PW_A = 3;
    localparam int H_B = 1, G_B = 1, PW_B = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick_a = 1'b0, tick_b = 1'b0;
    logic level_a, busy_a, ovf_a, level_b, busy_b, ovf_b;
    logic [PW_A-1:0] pend_a;
    logic [PW_B-1:0] pend_b;

    always #5 clk = ~clk;

    pulse_stretch #(.HIGH_CYCLES(H_A), .GAP_CYCLES(G_A), .PEND_W(PW_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .tick(tick_a), .level(level_a), .busy(busy_a),
        .pend(pend_a), .overflow(ovf_a));

    pulse_stretch #(.HIGH_CYCLES(H_B), .GAP_CYCLES(G_B), .PEND_W(PW_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .tick(tick_b), .level(level_b), .busy(busy_b),
        .pend(pend_b), .overflow(ovf_b));

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // Model: start cycle of the current/last pulse, queued count, overflow due this cycle.
    int m_s[2], m_q[2], m_ovf[2];
    int m_h[2]   = '{H_A, H_B};
    int m_g[2]   = '{G_A, G_B};
    int m_max[2] = '{(1 << PW_A) - 1, (1 << PW_B) - 1};

    int rises[2], ovfs[2], acc[2], prev_lvl[2], peak[2], hi_cnt[2], busy_cnt[2];

    task automatic expect_eq(input string tag, input logic [31:0] obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s[i] = -1000; m_q[i] = 0; m_ovf[i] = 0;
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            rises[i] = 0; ovfs[i] = 0; acc[i] = 0; peak[i] = 0;
            hi_cnt[i] = 0; busy_cnt[i] = 0;
        end
    endtask

    // Tick tk present during cycle c; updates the model to describe cycle c+1.
    task automatic advance(input int i, input int c, input int tk);
        int gap_end;
        gap_end = m_s[i] + m_h[i] + m_g[i] - 1;
        m_ovf[i] = 0;
        if (!(c >= m_s[i] && c <= gap_end)) begin
            if (tk != 0) begin m_s[i] = c + 1; acc[i]++; end
        end else if (c == gap_end) begin
            if (tk != 0) acc[i]++;
            if (m_q[i] > 0 || tk != 0) begin
                m_s[i] = c + 1;
                if (m_q[i] > 0) m_q[i] = m_q[i] - 1 + tk;
            end
        end else if (tk != 0) begin
            if (m_q[i] == m_max[i]) m_ovf[i] = 1;
            else begin m_q[i]++; acc[i]++; end
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            logic l, b, o;
            logic [31:0] p;
            int el, eb;
            el = (cyc >= m_s[i] && cyc < m_s[i] + m_h[i]) ? 1 : 0;
            eb = (cyc >= m_s[i] && cyc < m_s[i] + m_h[i] + m_g[i]) ? 1 : 0;
            if (i == 0) begin l = level_a; b = busy_a; o = ovf_a; p = 32'(pend_a); end
            else        begin l = level_b; b = busy_b; o = ovf_b; p = 32'(pend_b); end
            expect_eq($sformatf("level%0d@%0d", i, cyc), 32'(l), el);
            expect_eq($sformatf("busy%0d@%0d", i, cyc), 32'(b), eb);
            expect_eq($sformatf("pend%0d@%0d", i, cyc), p, m_q[i]);
            expect_eq($sformatf("ovf%0d@%0d", i, cyc), 32'(o), m_ovf[i]);
            if (l === 1'b1 && prev_lvl[i] == 0) rises[i]++;
            prev_lvl[i] = (l === 1'b1) ? 1 : 0;
            if (l === 1'b1) hi_cnt[i]++;
            if (b === 1'b1) busy_cnt[i]++;
            if (o === 1'b1) ovfs[i]++;
            if (int'(p) > peak[i]) peak[i] = int'(p);
        end
    endtask

    task automatic step(input int ta, input int tb);
        tick_a = ta[0];
        tick_b = tb[0];
        advance(0, cyc, ta);
        advance(1, cyc, tb);
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0);
    endtask

    initial begin
        model_reset();
        clear_stats();
        prev_lvl = '{0, 0};
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_outputs();

        // Single tick: one 4-cycle pulse, 6 busy cycles, queue untouched.
        idle(5);
        clear_stats();
        step(1, 0);
        idle(9);
        expect_eq("single_rises", 32'(rises[0]), 1);
        expect_eq("single_high", 32'(hi_cnt[0]), 4);
        expect_eq("single_busy", 32'(busy_cnt[0]), 6);

        // Tick on the last gap cycle with an empty queue: immediate re-rise.
        step(1, 0);
        idle(5);
        step(1, 0);
        expect_eq("gapend_level", 32'(level_a), 1);
        expect_eq("gapend_busy", 32'(busy_a), 1);
        expect_eq("gapend_pend", 32'(pend_a), 0);
        idle(12);

        // Saturation: tick held 10 cycles; one dropped, nine pulses.
        clear_stats();
        for (int k = 0; k < 10; k++) step(1, 0);
        idle(70);
        expect_eq("sat_rises", 32'(rises[0]), 9);
        expect_eq("sat_ovfs", 32'(ovfs[0]), 1);
        expect_eq("sat_peak", 32'(peak[0]), 7);

        // 1/1 timing, tick held 5 cycles: five one-cycle pulses, no overflow.
        clear_stats();
        for (int k = 0; k < 5; k++) step(0, 1);
        idle(20);
        expect_eq("h1_rises", 32'(rises[1]), 5);
        expect_eq("h1_high", 32'(hi_cnt[1]), 5);
        expect_eq("h1_ovfs", 32'(ovfs[1]), 0);

        // Random traffic in bursts of varying density; every accepted tick must become a pulse.
        clear_stats();
        for (int blk = 0; blk < 12; blk++) begin
            int dens;
            dens = (blk % 4 == 0) ? 5 : (blk % 4 == 1) ? 30 : (blk % 4 == 2) ? 70 : 95;
            for (int k = 0; k < 50; k++) begin
                step(($urandom_range(99, 0) < dens) ? 1 : 0,
                     ($urandom_range(99, 0) < dens) ? 1 : 0);
            end
        end
        idle(100);
        expect_eq("rand_pulses_a", 32'(rises[0]), acc[0]);
        expect_eq("rand_pulses_b", 32'(rises[1]), acc[1]);

        // Asynchronous reset mid-pulse with a queue of three.
        for (int k = 0; k < 4; k++) step(1, 0);
        expect_eq("pre_rst_pend", 32'(pend_a), 3);
        expect_eq("pre_rst_level", 32'(level_a), 1);
        tick_a = 1'b0;
        tick_b = 1'b0;
        rst_n = 1'b0;
        #1;
        expect_eq("rst_level", 32'(level_a), 0);
        expect_eq("rst_busy", 32'(busy_a), 0);
        expect_eq("rst_pend", 32'(pend_a), 0);
        expect_eq("rst_ovf", 32'(ovf_a), 0);
        model_reset();
        clear_stats();
        prev_lvl = '{0, 0};
        @(negedge clk); cyc++;
        @(negedge clk); cyc++;
        rst_n = 1'b1;
        check_outputs();
        idle(15);
        expect_eq("post_rst_rises", 32'(rises[0]), 0);
        step(1, 0);
        idle(8);
        expect_eq("post_rst_new", 32'(rises[0]), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
